// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single outstanding
// APB transfers and holds each completion in a response register until the
// consumer pops it.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   -> ACCESS phase aborts after TIMEOUT_CYCLES cycles of PREADY=0,
//                returning rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   undefined -> ACCESS waits indefinitely and rsp_timeout is tied low.
//
// Handshakes: a beat moves on an interface exactly in a cycle where both
// valid and ready are high at the rising clock edge. A command is accepted
// only in IDLE with no unconsumed response; cmd_ready never depends on
// rsp_ready, so a command offered in the pop cycle is taken one cycle later.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;
  logic                  w_to_hit;

  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and APB phase outputs; PSEL/PENABLE derive from state
  // alone so they can never be high in IDLE
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !r_rsp_valid;
        if (cmd_valid && !r_rsp_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL   = 1'b1;
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // A completing PREADY takes priority over a timeout in the same cycle
        if (PREADY) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // APB address/control/data captured at accept and held until the next one
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  // Response register: loaded on completion or abort, cleared on pop
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
      r_rsp_err   <= PSLVERR;
    end else if (w_abort) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYCLES itself
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_rsp_timeout;

  assign w_to_hit    = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = r_rsp_timeout;

  // Count stalled ACCESS cycles; cleared while in SETUP so each transfer starts at 0
  always_ff @(posedge CLK) begin
    if (!RSTN)                             r_to_cnt <= '0;
    else if (r_state == ST_SETUP)          r_to_cnt <= '0;
    else if (r_state == ST_ACCESS && !PREADY) r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Timeout flag travels with the response it belongs to
  always_ff @(posedge CLK) begin
    if (!RSTN)        r_rsp_timeout <= 1'b0;
    else if (w_done)  r_rsp_timeout <= 1'b0;
    else if (w_abort) r_rsp_timeout <= 1'b1;
  end
`else
  logic w_unused_timeout_cfg;

  assign w_to_hit             = 1'b0;
  assign rsp_timeout          = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
